comparador_serial_nb: RTL and testbench

// - Parametrised sequential magnitude comparator: compares two WIDTH-bit operands MSB-first, BITS_PER_CYCLE bits per clock.
// - Generalises the 1-bit comparator: any width, signed/unsigned mode, eq/gt/lt flags, start/busy/done handshake, optional early exit.
// - Sits beside datapath units that can accept a multi-cycle compare result in exchange for small area.

---
 rtl/comparador_serial_nb_if.sv | 25 ++
 rtl/comparador_serial_nb.sv | 139 +++++++++++++
 tb/tb_comparador_serial_nb.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/comparador_serial_nb_if.sv
// Handshake and operand/result bundle for the serial magnitude comparator.
// The master drives a request; the slave (the comparator) returns status and flags.
interface comparador_serial_nb_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, eq, gt, lt
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, eq, gt, lt
  );
endinterface

// File: rtl/comparador_serial_nb.sv
// Serial MSB-first magnitude comparator: BITS_PER_CYCLE bits per clock, signed or
// unsigned operands, start/busy/done handshake and optional early exit.
module comparador_serial_nb #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1,
  parameter int EARLY_EXIT     = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  comparador_serial_nb_if.slave  bus
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             decided_q, decided_d;
  logic             dec_gt_q, dec_gt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;

  logic [BITS_PER_CYCLE-1:0] slice_a;
  logic [BITS_PER_CYCLE-1:0] slice_b;
  logic                      slice_gt;
  logic                      slice_lt;
  logic                      any_dec;
  logic                      res_gt;
  logic [WIDTH-1:0]          msb_flip;

  assign slice_a  = a_q[WIDTH-1 -: BITS_PER_CYCLE];
  assign slice_b  = b_q[WIDTH-1 -: BITS_PER_CYCLE];
  assign slice_gt = slice_a > slice_b;
  assign slice_lt = slice_a < slice_b;

  // The first differing slice wins; later slices never override it.
  assign any_dec = decided_q | slice_gt | slice_lt;
  assign res_gt  = decided_q ? dec_gt_q : slice_gt;

  // Offset binary: flipping both sign bits makes two's complement order unsigned.
  assign msb_flip = {bus.signed_mode, {(WIDTH-1){1'b0}}};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    decided_d = decided_q;
    dec_gt_d  = dec_gt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    eq_d      = eq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d       = bus.a ^ msb_flip;
          b_d       = bus.b ^ msb_flip;
          cnt_d     = '0;
          decided_d = 1'b0;
          dec_gt_d  = 1'b0;
          eq_d      = 1'b0;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
          busy_d    = 1'b1;
          state_d   = RUN;
        end
      end

      RUN: begin
        a_d   = a_q << BITS_PER_CYCLE;
        b_d   = b_q << BITS_PER_CYCLE;
        cnt_d = cnt_q + 1'b1;
        if (!decided_q && (slice_gt || slice_lt)) begin
          decided_d = 1'b1;
          dec_gt_d  = slice_gt;
        end
        if ((EARLY_EXIT != 0 && (slice_gt || slice_lt)) || cnt_q == LAST) begin
          eq_d    = !any_dec;
          gt_d    = any_dec && res_gt;
          lt_d    = any_dec && !res_gt;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      decided_q <= 1'b0;
      dec_gt_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      decided_q <= decided_d;
      dec_gt_q  <= dec_gt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.eq   = eq_q;
  assign bus.gt   = gt_q;
  assign bus.lt   = lt_q;

endmodule

// File: tb/tb_comparador_serial_nb.sv
// Drives several comparator configurations with shared stimulus and checks every
// done pulse against an integer-arithmetic reference model through per-instance queues.
module tb_comparador_serial_nb;

  localparam int NCFG = 6;
  localparam logic [NCFG-1:0] ALL = '1;

  function automatic int cfg_w(input int g);
    case (g)
      4:       return 12;
      5:       return 6;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_bpc(input int g);
    case (g)
      2, 3:    return 4;
      4:       return 3;
      5:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int cfg_ee(input int g);
    return (g % 2 == 1) ? 1 : 0;
  endfunction

  typedef struct {
    int flags;
    int done_cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  int              cyc = 0;
  int              checks = 0;
  int              errors = 0;

  logic [NCFG-1:0] start_v;
  logic [NCFG-1:0] sgn_v;
  logic [15:0]     a_v [NCFG];
  logic [15:0]     b_v [NCFG];
  logic [NCFG-1:0] busy_v, done_v, eq_v, gt_v, lt_v;

  exp_t            exp_q [NCFG][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int W = cfg_w(g);
    comparador_serial_nb_if #(.WIDTH(W)) bus ();

    assign bus.start       = start_v[g];
    assign bus.signed_mode = sgn_v[g];
    assign bus.a           = a_v[g][W-1:0];
    assign bus.b           = b_v[g][W-1:0];
    assign busy_v[g]       = bus.busy;
    assign done_v[g]       = bus.done;
    assign eq_v[g]         = bus.eq;
    assign gt_v[g]         = bus.gt;
    assign lt_v[g]         = bus.lt;

    comparador_serial_nb #(
      .WIDTH          (W),
      .BITS_PER_CYCLE (cfg_bpc(g)),
      .EARLY_EXIT     (cfg_ee(g))
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );
  end

  // Reference: compare the operands as integers, derive latency from the highest differing bit.
  task automatic ref_model(input int w, input int bpc, input int ee, input bit sgn,
                           input logic [15:0] a, input logic [15:0] b,
                           output int flags, output int lat);
    int mask, va, vb, hi;
    mask = (1 << w) - 1;
    va   = int'(a) & mask;
    vb   = int'(b) & mask;
    if (sgn && a[w-1]) va = va - (1 << w);
    if (sgn && b[w-1]) vb = vb - (1 << w);
    if (va == vb)     flags = 3'b100;
    else if (va > vb) flags = 3'b010;
    else              flags = 3'b001;
    hi = -1;
    for (int i = w - 1; i >= 0; i--) begin
      if (hi < 0 && a[i] != b[i]) hi = i;
    end
    lat = w / bpc;
    if (ee != 0 && hi >= 0) lat = (w - 1 - hi) / bpc + 1;
  endtask

  task automatic checkOutput(input string name, input int g, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s cfg%0d actual=%0d expected=%0d (t=%0t)", name, g, actual, expected, $time);
    end
  endtask

  task automatic pushExp(input int g, input bit sgn, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   fl, lat;
    ref_model(cfg_w(g), cfg_bpc(g), cfg_ee(g), sgn, a, b, fl, lat);
    e.flags    = fl;
    e.done_cyc = cyc + lat;
    exp_q[g].push_back(e);
  endtask

  // Called just after a posedge; the request is taken only by instances that are idle.
  task automatic applyStimulus(input logic [NCFG-1:0] mask, input bit sgn,
                               input logic [15:0] a, input logic [15:0] b);
    logic [NCFG-1:0] idle;
    idle = ~busy_v;
    for (int g = 0; g < NCFG; g++) begin
      if (mask[g]) begin
        start_v[g] = 1'b1;
        sgn_v[g]   = sgn;
        a_v[g]     = a;
        b_v[g]     = b;
      end
    end
    @(posedge clk);
    #1;
    for (int g = 0; g < NCFG; g++) begin
      if (mask[g]) begin
        if (idle[g]) pushExp(g, sgn, a, b);
        start_v[g] = 1'b0;
        a_v[g]     = 16'($urandom);
        b_v[g]     = 16'($urandom);
        sgn_v[g]   = 1'($urandom);
      end
    end
  endtask

  task automatic waitAllIdle();
    int n;
    n = 0;
    while (busy_v != '0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy_v != '0) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout busy=%b expected=0", busy_v);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int g = 0; g < NCFG; g++) begin
        exp_t e;
        if (done_v[g]) begin
          if (exp_q[g].size() == 0) begin
            checkOutput("spurious_done", g, 1, 0);
          end else begin
            e = exp_q[g].pop_front();
            checkOutput("result_flags", g, {eq_v[g], gt_v[g], lt_v[g]}, e.flags);
            checkOutput("done_cycle", g, cyc, e.done_cyc);
            checkOutput("busy_at_done", g, busy_v[g], 0);
          end
        end else if (busy_v[g]) begin
          checkOutput("flags_while_busy", g, {eq_v[g], gt_v[g], lt_v[g]}, 0);
        end
      end
    end
  end

  initial begin
    int n;
    rst_n   = 1'b0;
    start_v = '0;
    sgn_v   = '0;
    for (int g = 0; g < NCFG; g++) begin
      a_v[g] = '0;
      b_v[g] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < NCFG; g++)
      checkOutput("reset_outputs", g, {busy_v[g], done_v[g], eq_v[g], gt_v[g], lt_v[g]}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(ALL, 1'b0, 16'h005A, 16'h005A); waitAllIdle();
    applyStimulus(ALL, 1'b0, 16'h0080, 16'h007F); waitAllIdle();
    applyStimulus(ALL, 1'b1, 16'h0080, 16'h007F); waitAllIdle();
    applyStimulus(ALL, 1'b0, 16'h0001, 16'h0000); waitAllIdle();
    applyStimulus(ALL, 1'b1, 16'h00FF, 16'h00FE); waitAllIdle();

    // A request arriving while every instance is busy must leave no trace.
    applyStimulus(ALL, 1'b0, 16'h005A, 16'h005B);
    applyStimulus(ALL, 1'b0, 16'h0000, 16'h00FF);
    waitAllIdle();

    // start held high: the second compare is taken on the edge after done.
    start_v[0] = 1'b1;
    sgn_v[0]   = 1'b0;
    a_v[0]     = 16'h0033;
    b_v[0]     = 16'h0044;
    @(posedge clk);
    #1;
    pushExp(0, 1'b0, 16'h0033, 16'h0044);
    a_v[0] = 16'h00C0;
    b_v[0] = 16'h000C;
    n = 0;
    while (!done_v[0] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("held_start_first_done", 0, done_v[0], 1);
    @(posedge clk);
    #1;
    pushExp(0, 1'b0, 16'h00C0, 16'h000C);
    start_v[0] = 1'b0;
    checkOutput("held_start_reaccepted", 0, busy_v[0], 1);
    waitAllIdle();

    // Reset in the middle of a run aborts it with no done.
    applyStimulus(ALL, 1'b0, 16'h005A, 16'h00A5);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < NCFG; g++) begin
      checkOutput("abort_outputs", g, {busy_v[g], done_v[g], eq_v[g], gt_v[g], lt_v[g]}, 0);
      exp_q[g].delete();
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(ALL, 1'b1, 16'h003C, 16'h00C3); waitAllIdle();

    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb;
      bit          rs;
      int          mode;
      ra   = 16'($urandom);
      mode = $urandom_range(3);
      if (mode == 0)      rb = ra;
      else if (mode == 1) rb = ra ^ (16'h1 << $urandom_range(11));
      else                rb = 16'($urandom);
      rs = 1'($urandom_range(1));
      applyStimulus(ALL, rs, ra, rb);
      waitAllIdle();
    end

    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NCFG; g++)
      checkOutput("pending_results", g, exp_q[g].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
